alu_result_stage: RTL and testbench

//  Registered write-back stage directly downstream of the 64-bit integer ALU.
//  - Captures each ALU result beat: Y plus flags C/N/Z/O.
//  - Maintains the architectural status register and the HI/LO scratch registers used by MUL/DIV.
//  - Queues register-file write beats in a 2-entry skid FIFO behind a valid/ready handshake.

---
 rtl/idp_pkg.sv | 52 +++++
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/wb_skid_fifo.sv | 76 +++++++
 rtl/alu_result_stage.sv | 86 ++++++++
 tb/tb_alu_result_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/idp_pkg.sv
// Shared definitions for the integer datapath write-back stage.
//   - ALU opcode constants that the result stage decodes
//   - status register bit positions {C,N,Z,O}
//   - wb_beat_t: one register-file write beat {addr, data}
//   - helpers that classify an opcode's side effects
package idp_pkg;

    localparam int DW         = 64;
    localparam int AW         = 5;
    localparam int SKID_DEPTH = 2;

    localparam logic [4:0] OP_MUL_LO  = 5'h02;
    localparam logic [4:0] OP_MUL_HI  = 5'h03;
    localparam logic [4:0] OP_DIV_Q   = 5'h04;
    localparam logic [4:0] OP_DIV_R   = 5'h05;
    localparam logic [4:0] OP_CMP     = 5'h11;
    localparam logic [4:0] OP_TST     = 5'h12;
    localparam logic [4:0] OP_LDFLAGS = 5'h17;

    localparam int ST_C = 3;
    localparam int ST_N = 2;
    localparam int ST_Z = 1;
    localparam int ST_O = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_beat_t;

    typedef enum logic [1:0] {
        HL_NONE = 2'd0,
        HL_LO   = 2'd1,
        HL_HI   = 2'd2
    } hilo_sel_e;

    function automatic hilo_sel_e decode_hilo(input logic [4:0] op);
        hilo_sel_e sel;
        sel = HL_NONE;
        if (op == OP_MUL_LO || op == OP_DIV_Q) begin
            sel = HL_LO;
        end else if (op == OP_MUL_HI || op == OP_DIV_R) begin
            sel = HL_HI;
        end
        return sel;
    endfunction

    // Load-flags only rewrites the status register; nothing goes to the register file.
    function automatic logic op_queues_beat(input logic [4:0] op);
        return (op != OP_LDFLAGS);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle between the ALU / register file and alu_result_stage.
//   upstream   : in_valid, in_ready, alu_op, alu_y, alu_flags, wb_addr_i, flush, clr_ovf
//   downstream : out_valid, out_ready, wb_addr, wb_data
//   state      : status {C,N,Z,O}, hi, lo
// slave modport is the stage itself; master is its environment.
interface alu_result_stage_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    alu_op;
    logic [DW-1:0] alu_y;
    logic [3:0]    alu_flags;
    logic [AW-1:0] wb_addr_i;
    logic          flush;
    logic          clr_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    status;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport slave (
        input  in_valid, alu_op, alu_y, alu_flags, wb_addr_i, flush, clr_ovf, out_ready,
        output in_ready, out_valid, wb_addr, wb_data, status, hi, lo
    );

    modport master (
        output in_valid, alu_op, alu_y, alu_flags, wb_addr_i, flush, clr_ovf, out_ready,
        input  in_ready, out_valid, wb_addr, wb_data, status, hi, lo
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry valid/ready FIFO of write-back beats with synchronous flush.
//   clk, reset_n   clock, async active-low reset
//   flush_i        empties the FIFO on the next edge; a same-cycle push survives
//   push_i/din_i   write request (only honoured while in_ready_o)
//   in_ready_o     registered "not full"; a pop does not raise it in the same cycle
//   out_valid_o    head entry present
//   out_ready_i    consumer takes the head
//   dout_o         head entry
module wb_skid_fifo
    import idp_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     flush_i,
    input  logic     push_i,
    input  wb_beat_t din_i,
    output logic     in_ready_o,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output wb_beat_t dout_o
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    wb_beat_t   mem_q [SKID_DEPTH];
    logic       do_push;
    logic       do_pop;
    logic       wr_sel;

    assign in_ready_o  = (count_q != 2'(SKID_DEPTH));
    assign out_valid_o = (count_q != 2'd0);
    assign do_push     = push_i & in_ready_o;
    assign do_pop      = out_valid_o & out_ready_i;
    assign dout_o      = mem_q[rd_ptr_q];
    // During a flush the surviving beat lands in slot 0 so it becomes the new head.
    assign wr_sel      = flush_i ? 1'b0 : wr_ptr_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = do_push ? 2'd1 : 2'd0;
            wr_ptr_d = do_push;
            rd_ptr_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_sel] <= din_i;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered write-back stage behind the 64-bit integer ALU.
// Decodes each accepted ALU beat: updates the {C,N,Z,O} status register,
// the HI/LO scratch registers for MUL/DIV, and queues register-file write
// beats in a 2-entry skid FIFO (wb_skid_fifo).
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    alu_result_stage_if: ALU beat in, write beat out, status/hi/lo
// Build option STATUS_STICKY_EN: status O bit is sticky, cleared only by clr_ovf
// (a same-cycle set wins). Without it, O is overwritten and clr_ovf is ignored.
module alu_result_stage
    import idp_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    alu_result_stage_if.slave bus
);

    logic          accept;
    logic          push;
    hilo_sel_e     hilo_sel;
    logic [3:0]    new_flags;
    logic [3:0]    status_q, status_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    wb_beat_t      beat_in;
    wb_beat_t      beat_out;
    logic          fifo_in_ready;

    assign accept    = bus.in_valid & fifo_in_ready;
    assign push      = accept & op_queues_beat(bus.alu_op);
    assign hilo_sel  = decode_hilo(bus.alu_op);
    assign new_flags = (bus.alu_op == OP_LDFLAGS) ? bus.alu_y[3:0] : bus.alu_flags;

    always_comb begin
        status_d = status_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            status_d = new_flags;
            if (hilo_sel == HL_LO) lo_d = bus.alu_y;
            if (hilo_sel == HL_HI) hi_d = bus.alu_y;
        end
`ifdef STATUS_STICKY_EN
        status_d[ST_O] = (accept & new_flags[ST_O]) | (status_q[ST_O] & ~bus.clr_ovf);
`endif
    end

`ifndef STATUS_STICKY_EN
    logic unused_clr_ovf;
    assign unused_clr_ovf = bus.clr_ovf;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= 4'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            status_q <= status_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign beat_in.addr = bus.wb_addr_i;
    assign beat_in.data = bus.alu_y;

    wb_skid_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (bus.flush),
        .push_i      (push),
        .din_i       (beat_in),
        .in_ready_o  (fifo_in_ready),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .dout_o      (beat_out)
    );

    assign bus.in_ready = fifo_in_ready;
    assign bus.wb_addr  = beat_out.addr;
    assign bus.wb_data  = beat_out.data;
    assign bus.status   = status_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    alu_result_stage_if #(.DW(64), .AW(5)) bus ();

    alu_result_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [4:0] op, input logic [63:0] y,
                            input logic [3:0] fl, input logic [4:0] a);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.alu_y     = y;
        bus.alu_flags = fl;
        bus.wb_addr_i = a;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(5'h00, 64'h99, 4'b0000, 5'd9);

        // 1: reset held with in_valid=1
        step();
        step();
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_status", 64'(bus.status), 64'd0);
        check_eq("rst_hi", bus.hi, 64'd0);
        check_eq("rst_lo", bus.lo, 64'd0);
        step();
        check_eq("rst_out_valid_late", 64'(bus.out_valid), 64'd0);
        reset_n = 1'b1;
        step();
        check_eq("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check_eq("post_rst_addr", 64'(bus.wb_addr), 64'd9);
        check_eq("post_rst_data", bus.wb_data, 64'h99);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_eq("post_rst_drain", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // 2: three back-to-back beats, consumer stalled
        set_beat(5'h00, 64'hA, 4'b0000, 5'd1);
        step();
        set_beat(5'h00, 64'hB, 4'b0000, 5'd2);
        step();
        set_beat(5'h00, 64'hC, 4'b0000, 5'd3);
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check_eq("full_in_ready_hold", 64'(bus.in_ready), 64'd0);
        check_eq("bb_head1_addr", 64'(bus.wb_addr), 64'd1);
        check_eq("bb_head1_data", bus.wb_data, 64'hA);
        bus.out_ready = 1'b1;
        step();
        check_eq("bb_head2_addr", 64'(bus.wb_addr), 64'd2);
        check_eq("bb_head2_data", bus.wb_data, 64'hB);
        check_eq("bb_in_ready_up", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_eq("bb_head3_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bb_head3_addr", 64'(bus.wb_addr), 64'd3);
        check_eq("bb_head3_data", bus.wb_data, 64'hC);
        step();
        check_eq("bb_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // 3: full FIFO, both sides active
        set_beat(5'h00, 64'h4, 4'b0000, 5'd4);
        step();
        set_beat(5'h00, 64'h5, 4'b0000, 5'd5);
        step();
        set_beat(5'h00, 64'h6, 4'b0000, 5'd6);
        bus.out_ready = 1'b1;
        check_eq("tp_in_ready_full", 64'(bus.in_ready), 64'd0);
        step();
        check_eq("tp_in_ready_lag", 64'(bus.in_ready), 64'd1);
        check_eq("tp_head5", 64'(bus.wb_addr), 64'd5);
        step();
        check_eq("tp_head6", 64'(bus.wb_addr), 64'd6);
        set_beat(5'h00, 64'h7, 4'b0000, 5'd7);
        step();
        check_eq("tp_head7", 64'(bus.wb_addr), 64'd7);
        check_eq("tp_in_ready_sus", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        step();
        check_eq("tp_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // 4: HI/LO and load-flags
        set_beat(5'h02, 64'h1234, 4'b0000, 5'd10);
        step();
        set_beat(5'h03, 64'hFFFF, 4'b1000, 5'd11);
        step();
        bus.in_valid = 1'b0;
        check_eq("op02_lo", bus.lo, 64'h1234);
        check_eq("op03_hi", bus.hi, 64'hFFFF);
        check_eq("op03_status", 64'(bus.status), 64'b1000);
        check_eq("hilo_two_queued", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        check_eq("hilo_beat1", 64'(bus.wb_addr), 64'd10);
        step();
        check_eq("hilo_beat2", 64'(bus.wb_addr), 64'd11);
        check_eq("hilo_beat2_data", bus.wb_data, 64'hFFFF);
        step();
        bus.out_ready = 1'b0;
        set_beat(5'h17, 64'h5, 4'b1111, 5'd12);
        step();
        bus.in_valid = 1'b0;
        check_eq("ldflags_status", 64'(bus.status), 64'b0101);
        check_eq("ldflags_no_beat", 64'(bus.out_valid), 64'd0);

        // 5: flush with two queued, new beat addr 7
        set_beat(5'h00, 64'h12, 4'b0101, 5'd12);
        step();
        set_beat(5'h00, 64'h13, 4'b0101, 5'd13);
        step();
        set_beat(5'h00, 64'h77, 4'b0101, 5'd7);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check_eq("flush_empty", 64'(bus.out_valid), 64'd0);
        check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_eq("flush_new_valid", 64'(bus.out_valid), 64'd1);
        check_eq("flush_new_addr", 64'(bus.wb_addr), 64'd7);
        check_eq("flush_new_data", bus.wb_data, 64'h77);
        check_eq("flush_status", 64'(bus.status), 64'b0101);
        check_eq("flush_hi", bus.hi, 64'hFFFF);
        check_eq("flush_lo", bus.lo, 64'h1234);
        bus.out_ready = 1'b1;
        step();
        check_eq("flush_sole_entry", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // flush with one queued and a same-cycle accept
        set_beat(5'h00, 64'h14, 4'b0101, 5'd14);
        step();
        set_beat(5'h00, 64'h15, 4'b0101, 5'd15);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flush_acc_valid", 64'(bus.out_valid), 64'd1);
        check_eq("flush_acc_addr", 64'(bus.wb_addr), 64'd15);
        bus.out_ready = 1'b1;
        step();
        check_eq("flush_acc_sole", 64'(bus.out_valid), 64'd0);

        // 6: overflow flag behaviour
        set_beat(5'h00, 64'h1, 4'b0001, 5'd0);
        step();
        check_eq("ovf_set", 64'(bus.status), 64'b0001);
        check_eq("r0_beat_queued", 64'(bus.out_valid), 64'd1);
        set_beat(5'h00, 64'h2, 4'b0000, 5'd1);
        step();
        bus.in_valid = 1'b0;
`ifdef STATUS_STICKY_EN
        check_eq("ovf_sticky", 64'(bus.status), 64'b0001);
`else
        check_eq("ovf_overwrite", 64'(bus.status), 64'b0000);
`endif
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check_eq("ovf_clr", 64'(bus.status), 64'b0000);
        set_beat(5'h00, 64'h3, 4'b0001, 5'd2);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf  = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("ovf_set_wins", 64'(bus.status), 64'b0001);

        // DIV quotient/remainder routing
        set_beat(5'h04, 64'h55, 4'b0000, 5'd3);
        step();
        check_eq("op04_lo", bus.lo, 64'h55);
        check_eq("op04_hi_keep", bus.hi, 64'hFFFF);
        set_beat(5'h05, 64'h66, 4'b0000, 5'd4);
        step();
        bus.in_valid = 1'b0;
        check_eq("op05_hi", bus.hi, 64'h66);
        check_eq("op05_lo_keep", bus.lo, 64'h55);
        step();
        bus.out_ready = 1'b0;

        // reset asserted mid-operation
        set_beat(5'h00, 64'h88, 4'b1010, 5'd8);
        step();
        bus.in_valid = 1'b0;
        check_eq("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mid_rst_status", 64'(bus.status), 64'd0);
        check_eq("mid_rst_hi", bus.hi, 64'd0);
        check_eq("mid_rst_lo", bus.lo, 64'd0);
        check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        reset_n = 1'b1;
        step();
        check_eq("mid_rst_lost", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
